// File: rtl/page_pkg.sv
// page_pkg: shared sequencer states and default widths for the page stream shim
package page_pkg;
  typedef enum logic [1:0] {HOLD, ARM, RUN} state_e;
  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int DEF_CNT_BITS = 32;
endpackage

// File: rtl/page_skid_buf.sv
// page_skid_buf: 2-entry registered FIFO skid buffer; accepts only while en_i is high
module page_skid_buf
  import page_pkg::*;
#(
  parameter int WIDTH = DEF_PAYLOAD_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  logic [WIDTH-1:0] mem_q [2];
  logic wp_q, rp_q, push, pop;
  logic [1:0] cnt_q, cnt_d;
  assign in_ready_o  = en_i && cnt_q != 2'd2;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o  = mem_q[rp_q];
  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;
  always_comb cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wp_q <= ~wp_q;
      if (pop) rp_q <= ~rp_q;
    end
    if (push) mem_q[wp_q] <= in_data_i;
  end
endmodule

// File: rtl/page_stream_shim.sv
// page_stream_shim: leaf_interface <-> HLS kernel glue with skid buffers and reset/start sequencer
// Per-stream beat counters exist only when PAGE_SHIM_STATS_EN is defined.
module page_stream_shim
  import page_pkg::*;
#(
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 1,
  parameter int START_DELAY   = 4,
  parameter int CNT_BITS      = DEF_CNT_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  if_data_in,
  input  logic [NUM_IN_PORTS-1:0]               if_valid_in,
  output logic [NUM_IN_PORTS-1:0]               if_ready_out,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  usr_data_out,
  output logic [NUM_IN_PORTS-1:0]               usr_valid_out,
  input  logic [NUM_IN_PORTS-1:0]               usr_ready_in,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] usr_data_in,
  input  logic [NUM_OUT_PORTS-1:0]              usr_valid_in,
  output logic [NUM_OUT_PORTS-1:0]              usr_ready_out,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_data_out,
  output logic [NUM_OUT_PORTS-1:0]              if_valid_out,
  input  logic [NUM_OUT_PORTS-1:0]              if_ready_in,
  output logic                                  ap_rst_n,
  output logic                                  ap_start
`ifdef PAGE_SHIM_STATS_EN
  ,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]      stat_in_cnt,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     stat_out_cnt
`endif
);
  state_e state_q, state_d;
  logic [31:0] dly_q, dly_d;
  logic rst_n_q, rst_n_d, start_q, start_d;
  always_comb begin
    state_d = state_q == HOLD ? (dly_q == 32'd0 ? ARM : HOLD) : RUN;
    dly_d   = (state_q == HOLD && dly_q != 32'd0) ? dly_q - 32'd1 : dly_q;
    rst_n_d = state_q != HOLD;
    start_d = state_q == RUN;
  end
  // Control outputs are registered from the state, so they trail the FSM by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      dly_q   <= 32'(START_DELAY);
      rst_n_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rst_n_q <= rst_n_d;
      start_q <= start_d;
    end
  end
  assign ap_rst_n = rst_n_q;
  assign ap_start = start_q;
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    page_skid_buf #(.WIDTH(PAYLOAD_BITS)) u_buf (
      .clk        (clk),
      .rst        (reset),
      .en_i       (start_q),
      .in_data_i  (if_data_in[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .in_valid_i (if_valid_in[i]),
      .in_ready_o (if_ready_out[i]),
      .out_data_o (usr_data_out[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .out_valid_o(usr_valid_out[i]),
      .out_ready_i(usr_ready_in[i])
    );
  end
  for (genvar o = 0; o < NUM_OUT_PORTS; o++) begin : g_out
    page_skid_buf #(.WIDTH(PAYLOAD_BITS)) u_buf (
      .clk        (clk),
      .rst        (reset),
      .en_i       (start_q),
      .in_data_i  (usr_data_in[o*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .in_valid_i (usr_valid_in[o]),
      .in_ready_o (usr_ready_out[o]),
      .out_data_o (if_data_out[o*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .out_valid_o(if_valid_out[o]),
      .out_ready_i(if_ready_in[o])
    );
  end
`ifdef PAGE_SHIM_STATS_EN
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_cnt
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (usr_valid_out[i] && usr_ready_in[i] && !(&cnt_q)) ? cnt_q + CNT_BITS'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
    assign stat_in_cnt[i*CNT_BITS +: CNT_BITS] = cnt_q;
  end
  for (genvar o = 0; o < NUM_OUT_PORTS; o++) begin : g_out_cnt
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (if_valid_out[o] && if_ready_in[o] && !(&cnt_q)) ? cnt_q + CNT_BITS'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
    assign stat_out_cnt[o*CNT_BITS +: CNT_BITS] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_page_stream_shim.sv
// tb_page_stream_shim: directed checks of sequencer timing, streaming, backpressure, reset flush and counters
module tb_page_stream_shim;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [63:0] a_din, a_udout;
  logic [1:0]  a_vin, a_rout, a_uvout, a_urin;
  logic [31:0] a_udin, a_idout;
  logic        a_uvin, a_urout, a_ivout, a_irin, a_rstn, a_start;
  logic [7:0]  b_din, b_udout, b_udin, b_idout;
  logic        b_vin, b_rout, b_uvout, b_urin, b_uvin, b_urout, b_ivout, b_irin, b_rstn, b_start;
`ifdef PAGE_SHIM_STATS_EN
  logic [63:0] a_sin;
  logic [31:0] a_sout;
  logic [3:0]  b_sin, b_sout;
`endif
  page_stream_shim #(
    .PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(1), .START_DELAY(4), .CNT_BITS(32)
  ) u_dut_a (
    .clk(clk), .reset(reset),
    .if_data_in(a_din), .if_valid_in(a_vin), .if_ready_out(a_rout),
    .usr_data_out(a_udout), .usr_valid_out(a_uvout), .usr_ready_in(a_urin),
    .usr_data_in(a_udin), .usr_valid_in(a_uvin), .usr_ready_out(a_urout),
    .if_data_out(a_idout), .if_valid_out(a_ivout), .if_ready_in(a_irin),
    .ap_rst_n(a_rstn), .ap_start(a_start)
`ifdef PAGE_SHIM_STATS_EN
    , .stat_in_cnt(a_sin), .stat_out_cnt(a_sout)
`endif
  );
  page_stream_shim #(
    .PAYLOAD_BITS(8), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(1), .START_DELAY(0), .CNT_BITS(4)
  ) u_dut_b (
    .clk(clk), .reset(reset),
    .if_data_in(b_din), .if_valid_in(b_vin), .if_ready_out(b_rout),
    .usr_data_out(b_udout), .usr_valid_out(b_uvout), .usr_ready_in(b_urin),
    .usr_data_in(b_udin), .usr_valid_in(b_uvin), .usr_ready_out(b_urout),
    .if_data_out(b_idout), .if_valid_out(b_ivout), .if_ready_in(b_irin),
    .ap_rst_n(b_rstn), .ap_start(b_start)
`ifdef PAGE_SHIM_STATS_EN
    , .stat_in_cnt(b_sin), .stat_out_cnt(b_sout)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    a_din = '0; a_vin = '0; a_urin = '0; a_udin = '0; a_uvin = 1'b0; a_irin = 1'b0;
    b_din = '0; b_vin = 1'b0; b_urin = 1'b1; b_udin = '0; b_uvin = 1'b0; b_irin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({a_rstn, a_start, a_rout, a_urout, a_uvout, a_ivout,
                          b_rstn, b_start, b_rout, b_urout, b_uvout, b_ivout}), 64'(0));
`ifdef PAGE_SHIM_STATS_EN
    check("rst_cnt_a_in", a_sin, 64'(0));
    check("rst_cnt_a_out", 64'(a_sout), 64'(0));
`endif
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("seq_a", 64'({a_rstn, a_start, a_rout, a_urout}),
            64'({k >= 5, k >= 6, {2{k >= 6}}, k >= 6}));
      check("seq_b", 64'({b_rstn, b_start, b_rout}), 64'({k >= 1, k >= 2, k >= 2}));
    end
    a_urin = 2'b11;
    a_vin[1] = 1'b1;
    a_din[63:32] = 32'h1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      check("s1_vld", 64'(a_uvout), 64'(2'b10));
      check("s1_dat", 64'(a_udout[63:32]), 64'(j));
      check("s1_rdy", 64'(a_rout), 64'(2'b11));
      if (j < 16) a_din[63:32] = 32'(j + 1);
      else a_vin[1] = 1'b0;
    end
    @(negedge clk);
    check("s1_end", 64'(a_uvout), 64'(0));
`ifdef PAGE_SHIM_STATS_EN
    check("s1_cnt", 64'(a_sin[63:32]), 64'(16));
    check("s0_cnt", 64'(a_sin[31:0]), 64'(0));
`endif
    b_vin = 1'b1;
    b_din = 8'h1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      check("b_dat", 64'({b_uvout, b_udout}), 64'({1'b1, 8'(j)}));
      if (j < 20) b_din = 8'(j + 1);
      else b_vin = 1'b0;
    end
    @(negedge clk);
    check("b_end", 64'(b_uvout), 64'(0));
`ifdef PAGE_SHIM_STATS_EN
    check("b_sat", 64'(b_sin), 64'(4'hF));
`endif
    a_irin = 1'b0;
    check("bp_rdy0", 64'(a_urout), 64'(1));
    a_uvin = 1'b1;
    a_udin = 32'hA5A5A5A5;
    @(negedge clk);
    check("bp1", 64'({a_urout, a_ivout, a_idout}), 64'({1'b1, 1'b1, 32'hA5A5A5A5}));
    a_udin = 32'h5A5A5A5A;
    @(negedge clk);
    check("bp2", 64'({a_urout, a_ivout, a_idout}), 64'({1'b0, 1'b1, 32'hA5A5A5A5}));
    a_udin = 32'hDEADBEEF;
    @(negedge clk);
    check("bp3", 64'({a_urout, a_ivout, a_idout}), 64'({1'b0, 1'b1, 32'hA5A5A5A5}));
    a_irin = 1'b1;
    @(negedge clk);
    check("bp4", 64'({a_urout, a_ivout, a_idout}), 64'({1'b1, 1'b1, 32'h5A5A5A5A}));
    @(negedge clk);
    check("bp5", 64'({a_urout, a_ivout, a_idout}), 64'({1'b1, 1'b1, 32'hDEADBEEF}));
    a_uvin = 1'b0;
    @(negedge clk);
    check("bp6", 64'(a_ivout), 64'(0));
`ifdef PAGE_SHIM_STATS_EN
    check("bp_cnt", 64'(a_sout), 64'(3));
`endif
    a_urin = 2'b00;
    a_irin = 1'b0;
    a_vin[0] = 1'b1;
    a_din[31:0] = 32'h11;
    a_uvin = 1'b1;
    a_udin = 32'h33;
    @(negedge clk);
    a_din[31:0] = 32'h22;
    a_udin = 32'h44;
    @(negedge clk);
    check("full", 64'({a_rout[0], a_urout, a_uvout[0], a_ivout}), 64'(4'b0011));
    reset = 1'b1;
    @(negedge clk);
    check("mr_ctl", 64'({a_rstn, a_start, a_rout, a_urout, a_uvout, a_ivout, b_rstn, b_start, b_uvout}),
          64'(0));
`ifdef PAGE_SHIM_STATS_EN
    check("mr_cnt", 64'({a_sin[63:32], a_sout}), 64'(0));
    check("mr_cnt_b", 64'(b_sin), 64'(0));
`endif
    reset = 1'b0;
    a_vin = 2'b00;
    a_uvin = 1'b0;
    a_urin = 2'b11;
    a_irin = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stale", 64'({a_uvout, a_ivout}), 64'(0));
    end
    a_vin[0] = 1'b1;
    a_din[31:0] = 32'h55;
    a_uvin = 1'b1;
    a_udin = 32'h66;
    @(negedge clk);
    check("fresh_in", 64'({a_uvout[0], a_udout[31:0]}), 64'({1'b1, 32'h55}));
    check("fresh_out", 64'({a_ivout, a_idout}), 64'({1'b1, 32'h66}));
    a_vin = 2'b00;
    a_uvin = 1'b0;
    @(negedge clk);
    check("fresh_end", 64'({a_uvout, a_ivout}), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
